// File: rtl/dataproc_mmio_pkg.sv
// Register map and bit positions for the pixel-pipeline MMIO control block.
package dataproc_mmio_pkg;

    localparam logic [7:0] OFF_CONTROL = 8'h00;
    localparam logic [7:0] OFF_STATUS  = 8'h04;
    localparam logic [7:0] OFF_PIXCNT  = 8'h08;
    localparam logic [7:0] OFF_OUTPUT  = 8'h0C;
    localparam logic [7:0] OFF_FRAMES  = 8'h10;
    localparam logic [7:0] OFF_LEVEL   = 8'h14;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_MODE_LO = 1;
    localparam int unsigned CTRL_MODE_HI = 2;
    localparam int unsigned CTRL_IRQ_EN  = 3;
    localparam int unsigned CTRL_CLEAR   = 4;

    localparam int unsigned STAT_BUSY   = 0;
    localparam int unsigned STAT_NEMPTY = 1;
    localparam int unsigned STAT_FULL   = 2;
    localparam int unsigned STAT_DONE   = 3;

endpackage

// File: rtl/dataproc_sync_fifo.sv
// Single-clock FIFO with flush; pushes are ignored while full, pops while empty.
module dataproc_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: contents are unreachable until pointers move.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/dataproc_mmio_ctrl.sv
// CPU-facing control/readback for data_proc: registers, output FIFO, pixel/frame counters, irq.
module dataproc_mmio_ctrl
    import dataproc_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0200_1000,
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned IMAGE_SIZE = 1024
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    output logic [31:0]      mem_rdata,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_pixel,
    output logic             proc_start,
    output logic [1:0]       proc_mode,
    output logic             irq
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CW = $clog2(IMAGE_SIZE);

    logic          mem_ready_q, mem_ready_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          start_q, start_d;
    logic [1:0]    mode_q, mode_d;
    logic          irq_en_q, irq_en_d;
    logic          done_q, done_d;
    logic          pop_pend_q, pop_pend_d;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic [31:0]   frames_q, frames_d;

    logic             in_window, is_wr, req, cmpl;
    logic [7:0]       off;
    logic             ctrl_wr, clear, w1c, xfer, frame_end;
    logic [PIX_W-1:0] fifo_rdata;
    logic [LW-1:0]    fifo_level;
    logic             fifo_full, fifo_empty;
    logic [31:0]      rd_val;
    logic             unused_ok;

    assign in_window = (mem_addr[31:8] == BASE_ADDR[31:8]);
    assign off       = mem_addr[7:0];
    assign is_wr     = |mem_wstrb;
    // Request cycle captures read data; completion cycle (mem_ready high) applies side effects.
    assign req       = mem_valid & in_window & ~mem_ready_q;
    assign cmpl      = mem_valid & in_window & mem_ready_q;
    assign ctrl_wr   = cmpl & is_wr & mem_wstrb[0] & (off == OFF_CONTROL);
    assign clear     = ctrl_wr & mem_wdata[CTRL_CLEAR];
    assign w1c       = cmpl & is_wr & mem_wstrb[0] & (off == OFF_STATUS) & mem_wdata[STAT_DONE];
    assign xfer      = s_valid & s_ready & ~clear;
    assign frame_end = xfer & (pix_cnt_q == CW'(IMAGE_SIZE - 1));
    assign unused_ok = ^mem_wdata[31:5];

    assign mem_ready  = mem_ready_q;
    assign mem_rdata  = rdata_q;
    assign proc_start = start_q;
    assign proc_mode  = mode_q;
    assign s_ready    = start_q & ~fifo_full;
    assign irq        = done_q & irq_en_q;

    dataproc_sync_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (xfer),
        .wdata  (s_pixel),
        .pop    (pop_pend_q),
        .flush  (clear),
        .rdata  (fifo_rdata),
        .level  (fifo_level),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_CONTROL: begin
                rd_val[CTRL_START]                 = start_q;
                rd_val[CTRL_MODE_HI:CTRL_MODE_LO]  = mode_q;
                rd_val[CTRL_IRQ_EN]                = irq_en_q;
            end
            OFF_STATUS: begin
                rd_val[STAT_BUSY]   = start_q | ~fifo_empty;
                rd_val[STAT_NEMPTY] = ~fifo_empty;
                rd_val[STAT_FULL]   = fifo_full;
                rd_val[STAT_DONE]   = done_q;
            end
            OFF_PIXCNT: rd_val = 32'(pix_cnt_q);
            OFF_OUTPUT: rd_val = fifo_empty ? 32'h0 : 32'({1'b1, fifo_rdata});
            OFF_FRAMES: rd_val = frames_q;
            OFF_LEVEL:  rd_val = 32'(fifo_level);
            default:    rd_val = '0;
        endcase
    end

    always_comb begin
        mem_ready_d = req;
        rdata_d     = (req & ~is_wr) ? rd_val : 32'h0;
        // Remember whether the read actually returned an entry, so a late push is never popped unseen.
        pop_pend_d  = req & ~is_wr & (off == OFF_OUTPUT) & ~fifo_empty;
        start_d     = start_q;
        mode_d      = mode_q;
        irq_en_d    = irq_en_q;
        pix_cnt_d   = pix_cnt_q;
        frames_d    = frames_q;
        done_d      = done_q;

        if (ctrl_wr) begin
            start_d  = mem_wdata[CTRL_START];
            mode_d   = mem_wdata[CTRL_MODE_HI:CTRL_MODE_LO];
            irq_en_d = mem_wdata[CTRL_IRQ_EN];
        end

        if (w1c) done_d = 1'b0;
        if (xfer) begin
            if (frame_end) begin
                pix_cnt_d = '0;
                frames_d  = frames_q + 32'd1;
                done_d    = 1'b1;
            end else begin
                pix_cnt_d = pix_cnt_q + CW'(1);
            end
        end

        if (clear) begin
            pix_cnt_d = '0;
            frames_d  = '0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_ready_q <= 1'b0;
            rdata_q     <= '0;
            pop_pend_q  <= 1'b0;
            start_q     <= 1'b0;
            mode_q      <= '0;
            irq_en_q    <= 1'b0;
            pix_cnt_q   <= '0;
            frames_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            mem_ready_q <= mem_ready_d;
            rdata_q     <= rdata_d;
            pop_pend_q  <= pop_pend_d;
            start_q     <= start_d;
            mode_q      <= mode_d;
            irq_en_q    <= irq_en_d;
            pix_cnt_q   <= pix_cnt_d;
            frames_q    <= frames_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_dataproc_mmio_ctrl.sv
// Directed bench for dataproc_mmio_ctrl built with a 4-pixel frame and 16-entry FIFO.
module tb_dataproc_mmio_ctrl;

    localparam logic [31:0] BASE = 32'h0200_1000;
    localparam logic [7:0]  A_CTRL = 8'h00, A_STAT = 8'h04, A_PIXC = 8'h08,
                            A_OUT  = 8'h0C, A_FRM  = 8'h10, A_LVL  = 8'h14;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [3:0]  mem_wstrb = 4'h0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_pixel = 8'h0;
    logic        proc_start;
    logic [1:0]  proc_mode;
    logic        irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  off;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t tab[$];

    dataproc_mmio_ctrl #(
        .BASE_ADDR  (BASE),
        .PIX_W      (8),
        .FIFO_DEPTH (16),
        .IMAGE_SIZE (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_wstrb  (mem_wstrb),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_pixel    (s_pixel),
        .proc_start (proc_start),
        .proc_mode  (proc_mode),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] st,
                       output logic [31:0] rd);
        bit got = 1'b0;
        rd = '0;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = BASE | 32'(off);
        mem_wdata = wd;
        mem_wstrb = st;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                got = 1'b1;
                rd  = mem_rdata;
                break;
            end
        end
        if (got) begin
            @(posedge clk); #1;
        end else begin
            total++;
            bad++;
            $display("FAIL bus_timeout off=0x%02h: got no mem_ready want mem_ready", off);
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    task automatic rd_chk(input logic [7:0] off, input logic [31:0] exp, input string name);
        logic [31:0] v;
        bus(off, 32'h0, 4'h0, v);
        check(name, v, exp);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] v;
        bus(off, d, 4'h1, v);
    endtask

    task automatic push(input logic [7:0] p);
        bit got = 1'b0;
        @(negedge clk);
        s_valid = 1'b1;
        s_pixel = p;
        for (int n = 0; n < 40; n++) begin
            if (s_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL push_timeout pixel=0x%02h: got s_ready=0 want 1", p);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    // Drives one pixel during the cycle mem_ready is high, so it lands on the completion edge.
    task automatic push_at_done(input logic [7:0] p);
        bit got = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            s_valid = 1'b1;
            s_pixel = p;
            @(posedge clk); #1;
            s_valid = 1'b0;
        end else begin
            total++;
            bad++;
            $display("FAIL sync_push_timeout: got no mem_ready want mem_ready");
        end
    endtask

    task automatic add(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] st,
                       input logic [31:0] exp, input string name);
        vec_t v;
        v.off = off; v.wdata = wd; v.strb = st; v.exp = exp; v.name = name;
        tab.push_back(v);
    endtask

    task automatic run_tab();
        logic [31:0] v;
        foreach (tab[i]) begin
            bus(tab[i].off, tab[i].wdata, tab[i].strb, v);
            if (tab[i].strb == 4'h0) check(tab[i].name, v, tab[i].exp);
        end
        tab.delete();
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_irq"},    32'(irq), 0);
        check({tag, "_sready"}, 32'(s_ready), 0);
        check({tag, "_start"},  32'(proc_start), 0);
        check({tag, "_mode"},   32'(proc_mode), 0);
        check({tag, "_mready"}, 32'(mem_ready), 0);
        check({tag, "_rdata"},  mem_rdata, 0);
        add(A_CTRL, 0, 0, 0, {tag, "_ctrl"});
        add(A_STAT, 0, 0, 0, {tag, "_status"});
        add(A_PIXC, 0, 0, 0, {tag, "_pixcnt"});
        add(A_OUT,  0, 0, 0, {tag, "_output"});
        add(A_FRM,  0, 0, 0, {tag, "_frames"});
        add(A_LVL,  0, 0, 0, {tag, "_level"});
        add(8'h18,  0, 0, 0, {tag, "_unmapped"});
        run_tab();
    endtask

    initial begin
        logic [31:0] v;
        int k;
        bit seen;

        // Reset values
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk) resetn = 1'b1;
        reset_checks("rst");

        // Out-of-window access never completes
        seen = 1'b0;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h0200_2004;
        repeat (3) begin
            @(posedge clk); #1;
            seen = seen | mem_ready;
        end
        mem_valid = 1'b0;
        check("outside_window_ready", 32'(seen), 0);

        // Single pixel
        wr(A_CTRL, 32'h1);
        check("start_out", 32'(proc_start), 1);
        push(8'hA5);
        add(A_LVL,  0, 0, 32'h1,   "single_level");
        add(A_PIXC, 0, 0, 32'h1,   "single_pixcnt");
        add(A_OUT,  0, 0, 32'h1A5, "single_pop");
        add(A_OUT,  0, 0, 32'h000, "single_empty_pop");
        add(A_LVL,  0, 0, 32'h0,   "single_level_after");
        add(A_CTRL, 0, 0, 32'h1,   "single_ctrl");
        add(A_STAT, 0, 0, 32'h1,   "single_status");
        run_tab();
        check("ready_pulse_low", 32'(mem_ready), 0);

        // Backpressure: 16 accepted, then stalled
        k = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_pixel = 8'(32'h10 + k);
            if (s_ready) k++;
        end
        s_valid = 1'b0;
        check("bp_transfers", 32'(k), 16);
        check("bp_sready_low", 32'(s_ready), 0);
        add(A_STAT, 0, 0, 32'hF,  "bp_status");
        add(A_LVL,  0, 0, 32'd16, "bp_level");
        add(A_PIXC, 0, 0, 32'd1,  "bp_pixcnt");
        add(A_FRM,  0, 0, 32'd4,  "bp_frames");
        add(A_OUT,  0, 0, 32'h110, "bp_pop0");
        run_tab();
        check("bp_sready_back", 32'(s_ready), 1);
        for (int i = 1; i < 16; i++) rd_chk(A_OUT, 32'h100 | 32'(8'h10 + i), $sformatf("bp_pop%0d", i));
        rd_chk(A_STAT, 32'h9, "bp_status_drained");

        // Frame completion with interrupt
        wr(A_CTRL, 32'h19);
        rd_chk(A_FRM, 32'h0, "clr_frames");
        for (int i = 0; i < 4; i++) begin
            push(8'(8'hC0 + i));
            rd_chk(A_OUT, 32'h100 | 32'(8'hC0 + i), $sformatf("frame_pop%0d", i));
        end
        check("frame_irq", 32'(irq), 1);
        add(A_PIXC, 0, 0, 32'h0, "frame_pixcnt");
        add(A_FRM,  0, 0, 32'h1, "frame_frames");
        add(A_STAT, 0, 0, 32'h9, "frame_status");
        add(A_STAT, 32'h8, 4'h1, 0, "frame_w1c");
        run_tab();
        check("frame_irq_cleared", 32'(irq), 0);
        push(8'hC4);
        rd_chk(A_PIXC, 32'h1, "fifth_pixcnt");

        // Clear mid-frame with 3 entries held
        push(8'hC5);
        push(8'hC6);
        add(A_LVL,  0, 0, 32'h3, "preclr_level");
        add(A_PIXC, 0, 0, 32'h3, "preclr_pixcnt");
        add(A_CTRL, 32'h11, 4'h1, 0, "clear_write");
        add(A_LVL,  0, 0, 32'h0, "clr_level");
        add(A_PIXC, 0, 0, 32'h0, "clr_pixcnt");
        add(A_FRM,  0, 0, 32'h0, "clr_frames2");
        add(A_CTRL, 0, 0, 32'h1, "clr_ctrl");
        add(A_OUT,  0, 0, 32'h0, "clr_output");
        run_tab();
        check("clr_start_kept", 32'(proc_start), 1);

        // Pop coinciding with push
        push(8'hD0);
        push(8'hD1);
        fork
            bus(A_OUT, 32'h0, 4'h0, v);
            push_at_done(8'hD2);
        join
        check("pushpop_data", v, 32'h1D0);
        add(A_LVL,  0, 0, 32'h2,   "pushpop_level");
        add(A_PIXC, 0, 0, 32'h3,   "pushpop_pixcnt");
        add(A_OUT,  0, 0, 32'h1D1, "pushpop_pop1");
        add(A_OUT,  0, 0, 32'h1D2, "pushpop_pop2");
        run_tab();

        // frame_done set coinciding with W1C
        fork
            bus(A_STAT, 32'h8, 4'h1, v);
            push_at_done(8'hE0);
        join
        add(A_STAT, 0, 0, 32'hB, "setwins_status");
        add(A_FRM,  0, 0, 32'h1, "setwins_frames");
        add(A_PIXC, 0, 0, 32'h0, "setwins_pixcnt");
        run_tab();

        // Clear coinciding with a transfer drops the pixel
        fork
            bus(A_CTRL, 32'h11, 4'h1, v);
            push_at_done(8'hE1);
        join
        add(A_LVL,  0, 0, 32'h0, "clrxfer_level");
        add(A_PIXC, 0, 0, 32'h0, "clrxfer_pixcnt");
        add(A_FRM,  0, 0, 32'h0, "clrxfer_frames");
        add(A_STAT, 0, 0, 32'h1, "clrxfer_status");
        run_tab();

        // Mode and mid-operation reset
        wr(A_CTRL, 32'h7);
        check("mode_out", 32'(proc_mode), 3);
        rd_chk(A_CTRL, 32'h7, "mode_ctrl");
        push(8'hF0);
        @(negedge clk) resetn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk) resetn = 1'b1;
        reset_checks("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dataproc_mmio_ctrl.md
# dataproc_mmio_ctrl

Memory-mapped control and readback block for the pixel processing pipeline. It is the parametrised successor to the fixed-width producer/processor wrapper. It drives `start`/`mode` into the processor and accepts the processor's output stream into an internal FIFO, so the CPU never misses pixels. It also counts pixels and frames, and raises a maskable frame-done interrupt. It sits on the rvsoc memory bus at `BASE_ADDR`, between the CPU and `data_proc`.

## Interface
- `BASE_ADDR`, 32'h0200_1000, base of the 256-byte register window
- `PIX_W`, 8, pixel width in bits (1..23)
- `FIFO_DEPTH`, 16, output FIFO entries (power of two, ≥2)
- `IMAGE_SIZE`, 1024, pixels per frame (≥2)
- `clk` in 1: system clock
- `resetn` in 1: reset, synchronous, active-low
- `mem_valid` in 1: bus request
- `mem_ready` out 1: one-cycle completion pulse
- `mem_wstrb` in 4: byte strobes; 0 means read
- `mem_addr` in 32: byte address
- `mem_wdata` in 32: write data
- `mem_rdata` out 32: read data, valid while `mem_ready`=1
- `s_valid` in 1: processor output valid
- `s_ready` out 1: accept from processor
- `s_pixel` in PIX_W: processor output pixel
- `proc_start` out 1: processor enable (equals CONTROL.start)
- `proc_mode` out 2: processor mode (equals CONTROL.mode)
- `irq` out 1: level interrupt

## Operation
- **Register window decode.** The window is `mem_addr[31:8]==BASE_ADDR[31:8]`. Every in-window access completes. Unmapped offsets read 0, and writes to them are ignored.
- **Register map:**
  - **0x00 CONTROL, R/W** (write honoured when `mem_wstrb[0]`=1):
    - [0] start
    - [2:1] mode
    - [3] irq_en
    - [4] clear: write-1, self-clearing, reads 0
  - **0x04 STATUS:**
    - [0] busy = start | ~empty
    - [1] ~empty
    - [2] full
    - [3] frame_done: sticky; writing 1 with `mem_wstrb[0]` clears it
  - **0x08 PIXEL_COUNT, RO:** pixels accepted in the current frame, range 0..IMAGE_SIZE-1.
  - **0x0C OUTPUT_DATA, RO, pop-on-read:**
    - [PIX_W] valid
    - [PIX_W-1:0] pixel
  - **0x10 FRAME_COUNT, RO:** 32-bit count of completed frames; wraps at 2^32.
  - **0x14 FIFO_LEVEL, RO:** occupancy, 0..FIFO_DEPTH.
- **Stream acceptance.**
  - `s_ready` = start & ~full.
  - A transfer occurs when `s_valid & s_ready`; it pushes `s_pixel` into the FIFO.
- **Pixel and frame counting.**
  - Each transfer increments PIXEL_COUNT.
  - A transfer at PIXEL_COUNT==IMAGE_SIZE-1 instead sets PIXEL_COUNT to 0, increments FRAME_COUNT, and sets frame_done.
- **Clearing start.** Deasserting start stops acceptance only. The FIFO, PIXEL_COUNT, FRAME_COUNT and frame_done are all held.
- **clear bit.** A write of clear=1 does the following on the completion cycle:
  - flushes the FIFO;
  - zeroes PIXEL_COUNT and FRAME_COUNT;
  - clears frame_done.
  - start, mode and irq_en are written from the same `mem_wdata` in that write.
- **OUTPUT_DATA read.**
  - Non-empty FIFO: returns {1, head} and pops on the completion cycle.
  - Empty FIFO: returns 0 and does not pop.
- **Interrupt.** `irq` = frame_done & irq_en.
- **Simultaneous events:**
  - **Push and pop in the same cycle:** both happen and the level is unchanged.
  - **frame_done set and W1C in the same cycle:** set wins.
  - **clear and transfer in the same cycle:** clear wins and the pixel is dropped.

## Timing
- **Bus handshake:**
  - `mem_ready` goes high exactly one cycle after a qualifying `mem_valid`, for one cycle, then low for at least one cycle.
  - `mem_ready` is computed as `in_window & mem_valid & ~mem_ready`.
  - `mem_rdata` is registered and captured from state as it stands on the request cycle. It is 0 whenever `mem_ready`=0.
- **Write effect:** register writes take effect on the `mem_ready` cycle. `proc_start`, `proc_mode` and `s_ready` reflect the write on the following cycle.
- **FIFO latency:** a pushed pixel is visible to an OUTPUT_DATA read that is issued on the cycle after the push.
- **Reset:** reset mid-operation discards everything. Reset values:
  - all outputs 0: `mem_ready`, `mem_rdata`, `s_ready`, `proc_start`, `proc_mode`, `irq`;
  - FIFO empty;
  - all counters 0.

## Structure
- **Package `dataproc_mmio_pkg`:**
  - register offset localparams: `OFF_CONTROL`, `OFF_STATUS`, `OFF_PIXCNT`, `OFF_OUTPUT`, `OFF_FRAMES`, `OFF_LEVEL`;
  - CONTROL and STATUS bit-index constants.
- **Sub-module `dataproc_sync_fifo`:**
  - parameters (WIDTH, DEPTH);
  - push, pop, flush;
  - `$clog2(DEPTH)+1`-bit level output;
  - full and empty outputs.
- **Top level:** decode, register file, counters and irq.

## Test plan
- **Reset values:** reset, then read every register → all 0, `irq`=0, `s_ready`=0.
- **Single pixel:**
  - Stimulus: write CONTROL=0x1, drive one pixel 0xA5.
  - FIFO_LEVEL=1 and PIXEL_COUNT=1.
  - OUTPUT_DATA read returns 0x1A5.
  - A second OUTPUT_DATA read returns 0x000.
- **Backpressure:**
  - Stimulus: start, hold `s_valid`=1 without reads for 20 cycles.
  - `s_ready` drops after 16 transfers; STATUS[2]=1; FIFO_LEVEL=16; no pixels lost.
  - Popping one entry re-asserts `s_ready` within one cycle.
- **Frame completion:**
  - Stimulus: IMAGE_SIZE=4, irq_en=1, feed 4 pixels with the reader draining.
  - PIXEL_COUNT=0, FRAME_COUNT=1, STATUS[3]=1, `irq`=1.
  - Writing STATUS=0x8 clears `irq`. A 5th pixel gives PIXEL_COUNT=1.
- **Clear:** mid-frame with the FIFO holding 3 entries, write CONTROL=0x11 → FIFO_LEVEL=0, PIXEL_COUNT=0, FRAME_COUNT=0, start remains 1.
- **Simultaneous events:**
  - A pop coinciding with a push leaves the level unchanged.
  - A frame_done set coinciding with a W1C leaves STATUS[3]=1.
